// File: rtl/fp_pkg.sv
// Shared types and constants for the FP adder issue/collect sequencer.
// Number format: 1b sign, 6b exponent (bias 31), 25b mantissa.
package fp_pkg;

    localparam int WORD_W   = 32;
    localparam int STATUS_W = 4;
    localparam int EXP_W    = 6;
    localparam int MANT_W   = 25;
    localparam int EXP_BIAS = 31;

    // Bit positions inside the adder's status word; the sequencer forwards it untouched.
    localparam int ST_OVERFLOW  = 0;
    localparam int ST_UNDERFLOW = 1;
    localparam int ST_ZERO      = 2;
    localparam int ST_INEXACT   = 3;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp32_t;

    typedef struct packed {
        logic [WORD_W-1:0] op_a;
        logic [WORD_W-1:0] op_b;
    } op_pair_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPT,
        HOLD
    } seq_state_t;

    function automatic fp32_t to_fp32(input logic [WORD_W-1:0] word);
        return fp32_t'(word);
    endfunction

endpackage

// File: rtl/fp_op_fifo.sv
// Operand-pair FIFO between the upstream source and the sequencer FSM.
// reset is synchronous and active-low; DEPTH must be a power of two.
module fp_op_fifo
    import fp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  op_pair_t                 push_data,
    input  logic                     pop,
    output op_pair_t                 head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    op_pair_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// Issue/collect stage for the multi-cycle FP adder: buffers operand pairs, pulses the
// adder reset once per operation, waits its fixed latency and returns the result.
module fp_add_sequencer
    import fp_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int FPU_LATENCY = 16
) (
    input  logic                clock_100kHz,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_op_a,
    input  logic [WORD_W-1:0]   in_op_b,
    output logic [WORD_W-1:0]   fpu_op_a,
    output logic [WORD_W-1:0]   fpu_op_b,
    output logic                fpu_reset,
    input  logic [WORD_W-1:0]   fpu_data,
    input  logic [STATUS_W-1:0] fpu_status,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_data,
    output logic [STATUS_W-1:0] out_status,
    output logic                busy
);

    localparam int CNT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FPU_LATENCY - 1);

    seq_state_t                state;
    logic [CNT_W-1:0]          cnt;
    fp32_t                     op_a_q;
    fp32_t                     op_b_q;
    fp32_t                     result_q;
    op_pair_t                  push_pair;
    op_pair_t                  head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      fetch;

    assign push_pair = '{op_a: in_op_a, op_b: in_op_b};

    fp_op_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock_100kHz),
        .reset     (reset),
        .push      (in_valid && in_ready),
        .push_data (push_pair),
        .pop       (fetch),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A new operation is fetched from IDLE, or straight out of HOLD on the result handshake.
    assign fetch = reset && !fifo_empty &&
                   ((state == IDLE) || ((state == HOLD) && out_ready));

    assign in_ready   = reset && !fifo_full;
    assign busy       = (state != IDLE) || (fifo_count != '0);
    assign fpu_op_a   = op_a_q;
    assign fpu_op_b   = op_b_q;
    assign out_data   = result_q;

    always_ff @(posedge clock_100kHz) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            fpu_reset  <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            result_q   <= '0;
            out_status <= '0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    fpu_reset <= 1'b1;
                    if (fetch) begin
                        op_a_q    <= to_fp32(head.op_a);
                        op_b_q    <= to_fp32(head.op_b);
                        fpu_reset <= 1'b0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    fpu_reset <= 1'b1;
                    cnt       <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    result_q   <= to_fp32(fpu_data);
                    out_status <= fpu_status;
                    out_valid  <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (fetch) begin
                            op_a_q    <= to_fp32(head.op_a);
                            op_b_q    <= to_fp32(head.op_b);
                            fpu_reset <= 1'b0;
                            state     <= LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    fpu_reset <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Self-checking bench for fp_add_sequencer with a stub adder that returns op_a^op_b.
module tb_fp_add_sequencer;

    localparam int DEPTH = 4;
    localparam int LAT   = 16;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } vec_t;

    logic        clock_100kHz = 1'b0;
    logic        reset        = 1'b0;
    logic        in_valid     = 1'b0;
    logic        out_ready    = 1'b0;
    logic [31:0] in_op_a      = '0;
    logic [31:0] in_op_b      = '0;
    logic        in_ready;
    logic [31:0] fpu_op_a;
    logic [31:0] fpu_op_b;
    logic        fpu_reset;
    logic [31:0] fpu_data;
    logic [3:0]  fpu_status;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_status;
    logic        busy;

    logic [5:0]  stub_cnt = '0;
    logic [35:0] sb [$];
    vec_t        vecs [6];
    int          checks = 0;
    int          errors = 0;

    fp_add_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .FPU_LATENCY (LAT)
    ) dut (
        .clock_100kHz (clock_100kHz),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op_a      (in_op_a),
        .in_op_b      (in_op_b),
        .fpu_op_a     (fpu_op_a),
        .fpu_op_b     (fpu_op_b),
        .fpu_reset    (fpu_reset),
        .fpu_data     (fpu_data),
        .fpu_status   (fpu_status),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_status   (out_status),
        .busy         (busy)
    );

    always #5 clock_100kHz = ~clock_100kHz;

    // Stub adder: result valid LAT edges after its reset is released.
    always @(posedge clock_100kHz) begin
        if (!fpu_reset) begin
            stub_cnt <= '0;
        end else if (stub_cnt < 6'(LAT)) begin
            stub_cnt <= stub_cnt + 6'd1;
        end
    end

    assign fpu_data   = (stub_cnt >= 6'(LAT)) ? (fpu_op_a ^ fpu_op_b) : 32'hDEAD_DEAD;
    assign fpu_status = (stub_cnt >= 6'(LAT)) ? 4'hA : 4'h0;

    task automatic check_output(input string name, input logic [35:0] actual,
                                input logic [35:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Result monitor: pops the scoreboard on every accepted result.
    always @(negedge clock_100kHz) begin
        #1;
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got %h expected none at %0t",
                         {out_data, out_status}, $time);
            end else begin
                check_output("result", {out_data, out_status}, sb.pop_front());
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic apply_stimulus(input vec_t v);
        bit done = 1'b0;
        in_op_a  = v.a;
        in_op_b  = v.b;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (in_ready) begin
                sb.push_back({v.sum, 4'hA});
                @(posedge clock_100kHz);
                @(negedge clock_100kHz);
                done = 1'b1;
            end else begin
                @(negedge clock_100kHz);
            end
        end
        in_valid = 1'b0;
        if (!done) fail_now("push_timeout");
    endtask

    task automatic wait_out_valid(input int budget);
        int i = 0;
        while (!out_valid && i < budget) begin
            @(negedge clock_100kHz);
            i++;
        end
        if (!out_valid) fail_now("out_valid_timeout");
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while ((sb.size() != 0 || busy) && i < budget) begin
            @(negedge clock_100kHz);
            i++;
        end
        if (sb.size() != 0 || busy) fail_now("drain_timeout");
    endtask

    task automatic check_reset_values();
        check_output("rst_fpu_reset", 36'(fpu_reset), 36'd0);
        check_output("rst_fpu_op_a",  36'(fpu_op_a),  36'd0);
        check_output("rst_fpu_op_b",  36'(fpu_op_b),  36'd0);
        check_output("rst_out_valid", 36'(out_valid), 36'd0);
        check_output("rst_out_data",  36'(out_data),  36'd0);
        check_output("rst_out_status", 36'(out_status), 36'd0);
        check_output("rst_busy",      36'(busy),      36'd0);
        check_output("rst_in_ready",  36'(in_ready),  36'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int low_cnt;
        int bad;
        int vld_cnt;

        vecs[0] = '{32'h3E00_0000, 32'h4000_0000, 32'h7E00_0000};
        vecs[1] = '{32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
        vecs[2] = '{32'h1234_5678, 32'h1111_1111, 32'h0325_4769};
        vecs[3] = '{32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{32'h8000_0001, 32'h0000_0001, 32'h8000_0000};

        repeat (3) @(negedge clock_100kHz);
        check_reset_values();
        reset = 1'b1;
        @(negedge clock_100kHz);
        check_output("post_rst_in_ready",  36'(in_ready),  36'd1);
        check_output("post_rst_fpu_reset", 36'(fpu_reset), 36'd1);

        // Single operation: exact latency and a single adder reset pulse.
        out_ready = 1'b0;
        apply_stimulus(vecs[0]);
        low_cnt = 0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clock_100kHz);
            if (!fpu_reset) low_cnt++;
            if (k == 18) check_output("valid_not_early", 36'(out_valid), 36'd0);
            if (k == 19) check_output("valid_on_time",   36'(out_valid), 36'd1);
        end
        check_output("one_reset_pulse", 36'(low_cnt), 36'd1);
        check_output("first_data", {out_data, out_status}, {32'h7E00_0000, 4'hA});

        // Hold the result with a second pair waiting.
        apply_stimulus(vecs[1]);
        bad = 0;
        repeat (30) begin
            @(negedge clock_100kHz);
            if (!out_valid || out_data !== 32'h7E00_0000 || out_status !== 4'hA ||
                fpu_op_a !== vecs[0].a || fpu_op_b !== vecs[0].b) bad++;
        end
        check_output("hold_stable", 36'(bad), 36'd0);
        out_ready = 1'b1;
        @(negedge clock_100kHz);
        check_output("next_load_reset", 36'(fpu_reset), 36'd0);
        check_output("next_load_op_a",  36'(fpu_op_a),  36'(vecs[1].a));
        check_output("cleared_valid",   36'(out_valid), 36'd0);
        wait_drain(300);

        // Five back-to-back pushes: one popped on the second edge, four left -> full.
        for (int i = 1; i < 6; i++) apply_stimulus(vecs[i]);
        check_output("full_after_five", 36'(in_ready), 36'd0);
        wait_drain(400);

        // Push on the same edge as a HOLD pop with the FIFO holding three pairs.
        out_ready = 1'b0;
        apply_stimulus(vecs[0]);
        apply_stimulus(vecs[2]);
        apply_stimulus(vecs[3]);
        apply_stimulus(vecs[4]);
        wait_out_valid(60);
        out_ready = 1'b1;
        apply_stimulus(vecs[5]);
        check_output("push_pop_not_full", 36'(in_ready), 36'd1);
        check_output("push_pop_order",    36'(fpu_op_a), 36'(vecs[2].a));
        wait_drain(400);

        // Reset during RUN with two pairs queued.
        apply_stimulus(vecs[1]);
        apply_stimulus(vecs[2]);
        apply_stimulus(vecs[3]);
        repeat (8) @(negedge clock_100kHz);
        check_output("in_run_busy", 36'(busy), 36'd1);
        reset = 1'b0;
        sb.delete();
        repeat (2) @(negedge clock_100kHz);
        check_reset_values();
        reset = 1'b1;
        vld_cnt = 0;
        repeat (50) begin
            @(negedge clock_100kHz);
            if (out_valid) vld_cnt++;
        end
        check_output("no_result_after_reset", 36'(vld_cnt), 36'd0);
        check_output("idle_after_reset",      36'(busy),    36'd0);

        // Table sweep: six pairs wrap the FIFO pointers.
        for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);
        wait_drain(500);
        check_output("scoreboard_empty", 36'(sb.size()), 36'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
